// File: rtl/rsp_router_16.sv
// Routes in-order responses from a shared target back to the requester that was granted,
// using a FIFO of grant indices and a single registered output stage.
module rsp_router_16 #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       grant_vld,
  input  logic [3:0]                 grant_idx,
  output logic                       grant_rdy,
  input  logic                       rsp_vld,
  input  logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_rdy,
  output logic [15:0]                out_vld,
  output logic [DATA_W-1:0]          out_data,
  input  logic [15:0]                out_rdy,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_unexp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]        fifo_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_full_q, out_full_d;
  logic [3:0]        out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic              fifo_empty;
  logic              stage_free;
  logic              push;
  logic              pop;
  logic [3:0]        head_idx;

  always_comb begin
    fifo_empty = (count_q == '0);
    grant_rdy  = (count_q < CNT_W'(DEPTH));
    stage_free = !out_full_q || out_rdy[out_idx_q];
    rsp_rdy    = fifo_empty || stage_free;
    push       = grant_vld && grant_rdy;
    // A beat arriving with nothing queued is dropped, even if a grant lands this cycle.
    pop        = rsp_vld && !fifo_empty && stage_free;
    head_idx   = fifo_mem[rd_ptr_q];

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_full_d = out_full_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    err_d      = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      out_full_d = 1'b1;
      out_idx_d  = head_idx;
      out_data_d = rsp_data;
    end else if (out_full_q && out_rdy[out_idx_q]) begin
      out_full_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (rsp_vld && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // Index storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_full_q <= 1'b0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_full_q <= out_full_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  assign out_vld     = out_full_q ? (16'b1 << out_idx_q) : 16'b0;
  assign out_data    = out_data_q;
  assign outstanding = count_q;
  assign err_unexp   = err_q;

endmodule

// File: tb/tb_rsp_router_16.sv
// Scoreboard bench for rsp_router_16: a queue-based model of pending grants and delivered
// beats is updated on every falling edge and compared against the DUT outputs.
module tb_rsp_router_16;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              grant_vld;
  logic [3:0]        grant_idx;
  logic              grant_rdy;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_rdy;
  logic [15:0]       out_vld;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       out_rdy;
  logic [CNT_W-1:0]  outstanding;
  logic              err_unexp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]        idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [3:0] pend_q [$];
  beat_t      sb_q [$];
  bit         err_exp = 1'b0;

  always #5 clk = ~clk;

  rsp_router_16 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_vld   (grant_vld),
    .grant_idx   (grant_idx),
    .grant_rdy   (grant_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_data    (rsp_data),
    .rsp_rdy     (rsp_rdy),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_rdy     (out_rdy),
    .outstanding (outstanding),
    .err_unexp   (err_unexp)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor / reference model: sampled mid-cycle, ahead of the edge that commits the handshakes.
  logic [15:0] m_exp_vld;
  bit          m_exp_rdy;
  int          m_n0;
  beat_t       m_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      sb_q.delete();
      err_exp = 1'b0;
    end else begin
      m_n0      = pend_q.size();
      m_exp_vld = (sb_q.size() != 0) ? (16'(1) << sb_q[0].idx) : 16'h0;
      chk("out_vld", DATA_W'(out_vld), DATA_W'(m_exp_vld));
      chk("outstanding", DATA_W'(outstanding), DATA_W'(m_n0));
      chk("grant_rdy", DATA_W'(grant_rdy), DATA_W'(m_n0 < DEPTH));
      chk("err_unexp", DATA_W'(err_unexp), DATA_W'(err_exp));
      if (sb_q.size() != 0) begin
        chk("out_data", out_data, sb_q[0].data);
        if (out_rdy[sb_q[0].idx]) begin
          $display("beat idx %0d data %0h", sb_q[0].idx, sb_q[0].data);
          void'(sb_q.pop_front());
        end
      end
      m_exp_rdy = (m_n0 == 0) || (sb_q.size() == 0);
      chk("rsp_rdy", DATA_W'(rsp_rdy), DATA_W'(m_exp_rdy));
      if (rsp_vld) begin
        if (m_n0 == 0) begin
          err_exp = 1'b1;
        end else if (m_exp_rdy) begin
          m_b.idx  = pend_q.pop_front();
          m_b.data = rsp_data;
          sb_q.push_back(m_b);
        end
      end
      if (grant_vld && m_n0 < DEPTH) pend_q.push_back(grant_idx);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [3:0] idx);
    grant_vld = 1'b1;
    grant_idx = idx;
    tick(1);
    grant_vld = 1'b0;
  endtask

  task automatic rsp(input logic [DATA_W-1:0] d);
    bit acc;
    acc      = 1'b0;
    rsp_vld  = 1'b1;
    rsp_data = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (rsp_rdy) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    rsp_vld = 1'b0;
    if (!acc) chk("rsp_accept_timeout", DATA_W'(0), DATA_W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] da, db, dc;
    int g, r;
    bit acc;

    rst_n     = 1'b1;
    grant_vld = 1'b0;
    grant_idx = '0;
    rsp_vld   = 1'b0;
    rsp_data  = '0;
    out_rdy   = 16'hFFFF;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_out_vld", DATA_W'(out_vld), DATA_W'(0));
    chk("rst_outstanding", DATA_W'(outstanding), DATA_W'(0));
    chk("rst_err", DATA_W'(err_unexp), DATA_W'(0));
    chk("rst_out_data", out_data, DATA_W'(0));
    chk("rst_grant_rdy", DATA_W'(grant_rdy), DATA_W'(1));
    chk("rst_rsp_rdy", DATA_W'(rsp_rdy), DATA_W'(1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1);

    // Grants 3,7,3 then back-to-back responses.
    da = rnd_data(); db = rnd_data(); dc = rnd_data();
    grant(4'd3); grant(4'd7); grant(4'd3);
    rsp(da); rsp(db); rsp(dc);
    tick(2);

    // Fill to DEPTH, pop with a (refused) grant, then pop+push together.
    for (int i = 0; i < DEPTH; i++) grant(4'(i));
    tick(2);
    grant_vld = 1'b1; grant_idx = 4'd9; rsp_vld = 1'b1; rsp_data = rnd_data();
    tick(1);
    grant_idx = 4'd11; rsp_data = rnd_data();
    tick(1);
    grant_vld = 1'b0; rsp_vld = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) rsp(rnd_data());
    tick(2);

    // Back-pressure on requester 5 only; second response must stall.
    out_rdy = 16'hFFDF;
    grant(4'd5); grant(4'd9);
    rsp(da);
    rsp_vld = 1'b1; rsp_data = db;
    tick(4);
    out_rdy = 16'hFFFF;
    rsp(db);
    tick(2);

    // Unexpected response, including one alongside a grant.
    rsp_vld = 1'b1; rsp_data = rnd_data();
    tick(1);
    rsp_vld = 1'b0;
    tick(2);
    grant_vld = 1'b1; grant_idx = 4'd2; rsp_vld = 1'b1; rsp_data = rnd_data();
    tick(1);
    grant_vld = 1'b0; rsp_vld = 1'b0;
    rsp(dc);
    tick(2);

    // Random traffic with back-pressure across pointer wrap.
    g = 0; r = 0;
    for (int cyc = 0; cyc < 5000 && r < 40; cyc++) begin
      grant_vld = (g < 40) && ($urandom_range(0, 1) == 1);
      grant_idx = 4'($urandom_range(0, 15));
      if (!rsp_vld && r < g && $urandom_range(0, 2) != 0) begin
        rsp_vld  = 1'b1;
        rsp_data = rnd_data();
      end
      out_rdy = ($urandom_range(0, 2) != 0) ? 16'hFFFF : 16'($urandom);
      @(negedge clk);
      acc = 1'b0;
      if (grant_vld && grant_rdy) g++;
      if (rsp_vld && rsp_rdy) begin r++; acc = 1'b1; end
      @(posedge clk);
      #1;
      if (acc) rsp_vld = 1'b0;
    end
    grant_vld = 1'b0; rsp_vld = 1'b0; out_rdy = 16'hFFFF;
    chk("random_rsp_count", DATA_W'(r), DATA_W'(40));
    tick(3);
    chk("random_sb_drained", DATA_W'(sb_q.size()), DATA_W'(0));
    chk("random_pend_drained", DATA_W'(pend_q.size()), DATA_W'(0));

    // Mid-operation reset with 5 queued and a held beat; err_unexp is still set.
    out_rdy = 16'h0000;
    for (int i = 1; i <= 6; i++) grant(4'(i));
    rsp(da);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_vld", DATA_W'(out_vld), DATA_W'(0));
    chk("arst_outstanding", DATA_W'(outstanding), DATA_W'(0));
    chk("arst_err", DATA_W'(err_unexp), DATA_W'(0));
    chk("arst_grant_rdy", DATA_W'(grant_rdy), DATA_W'(1));
    chk("arst_rsp_rdy", DATA_W'(rsp_rdy), DATA_W'(1));
    chk("arst_out_data", out_data, DATA_W'(0));
    tick(2);
    #2 rst_n = 1'b1;
    out_rdy = 16'hFFFF;
    tick(1);
    grant(4'd12);
    rsp(db);
    tick(3);
    chk("final_sb_drained", DATA_W'(sb_q.size()), DATA_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
